// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing sets, timing struct and sync polarity constants.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
        logic      hpol;
        logic      vpol;
    } vga_timing_t;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    localparam int MAX_PIXEL_LATENCY = 7;

    localparam vga_timing_t VGA_640X480_60 = '{
        h:    '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48},
        v:    '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33},
        hpol: SYNC_ACTIVE_LOW,
        vpol: SYNC_ACTIVE_LOW
    };

    localparam vga_timing_t VGA_800X600_60 = '{
        h:    '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88},
        v:    '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23},
        hpol: SYNC_ACTIVE_HIGH,
        vpol: SYNC_ACTIVE_HIGH
    };

    function automatic int axis_total(input vga_axis_t a);
        return int'(a.active) + int'(a.fp) + int'(a.sync) + int'(a.bp);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - Pixel-side bundle between timing generator, renderer and pins.
interface vga_timing_gen_if #(
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int COLOR_W = 4
);
    logic               pix_en;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic               active;
    logic               line_start;
    logic               frame_start;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] vga_red;
    logic [COLOR_W-1:0] vga_green;
    logic [COLOR_W-1:0] vga_blue;

    modport master (
        input  pix_en, red, green, blue,
        output x, y, active, line_start, frame_start,
               hsync, vsync, vga_red, vga_green, vga_blue
    );

    modport slave (
        output pix_en, red, green, blue,
        input  x, y, active, line_start, frame_start,
               hsync, vsync, vga_red, vga_green, vga_blue
    );
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - Enable-gated shift register; DEPTH=0 is a straight wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        assign data_o = data_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (en_i) begin
                stage_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - Parametrised VGA H/V counters, region decode, strobes and pin stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = int'(VGA_640X480_60.h.active),
    parameter int H_FP          = int'(VGA_640X480_60.h.fp),
    parameter int H_SYNC        = int'(VGA_640X480_60.h.sync),
    parameter int H_BP          = int'(VGA_640X480_60.h.bp),
    parameter int V_ACTIVE      = int'(VGA_640X480_60.v.active),
    parameter int V_FP          = int'(VGA_640X480_60.v.fp),
    parameter int V_SYNC        = int'(VGA_640X480_60.v.sync),
    parameter int V_BP          = int'(VGA_640X480_60.v.bp),
    parameter bit HSYNC_POL     = SYNC_ACTIVE_LOW,
    parameter bit VSYNC_POL     = SYNC_ACTIVE_LOW,
    parameter int COLOR_W       = 4,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW:0]   H_VIS    = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0]   HS_BEGIN = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0]   HS_END   = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0]   V_VIS    = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0]   VS_BEGIN = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0]   VS_END   = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
        PIXEL_LATENCY < 0 || PIXEL_LATENCY > MAX_PIXEL_LATENCY) begin : g_param_check
        $error("vga_timing_gen: timing parameter is zero or PIXEL_LATENCY out of 0..7");
    end

    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               x_wrap, y_wrap;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    logic               active_raw, hs_raw, vs_raw;
    logic [2:0]         dl_in, dl_out;

    // Region is a pure compare on the counters, so it can never skew against x/y.
    always_comb begin
        active_raw = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
        hs_raw     = ({1'b0, x_q} >= HS_BEGIN) && ({1'b0, x_q} < HS_END);
        vs_raw     = ({1'b0, y_q} >= VS_BEGIN) && ({1'b0, y_q} < VS_END);
        dl_in      = {active_raw, hs_raw, vs_raw};
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIXEL_LATENCY)
    ) u_align (
        .clk    (clk),
        .rst    (reset),
        .en_i   (vga.pix_en),
        .data_i (dl_in),
        .data_o (dl_out)
    );

    always_comb begin
        x_wrap        = (x_q == X_LAST);
        y_wrap        = (y_q == Y_LAST);
        x_d           = x_wrap ? '0 : x_q + XW'(1);
        y_d           = y_q;
        if (x_wrap) begin
            y_d = y_wrap ? '0 : y_q + YW'(1);
        end
        line_start_d  = vga.pix_en && x_wrap;
        frame_start_d = vga.pix_en && x_wrap && y_wrap;
        hsync_d       = dl_out[1] ^ ~HSYNC_POL;
        vsync_d       = dl_out[0] ^ ~VSYNC_POL;
        red_d         = dl_out[2] ? vga.red   : '0;
        green_d       = dl_out[2] ? vga.green : '0;
        blue_d        = dl_out[2] ? vga.blue  : '0;
    end

    // Strobes are refreshed every clk so they stay one clk wide even with a sparse pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (vga.pix_en) begin
                x_q     <= x_d;
                y_q     <= y_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.active      = active_raw;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.vga_red     = red_q;
    assign vga.vga_green   = green_q;
    assign vga.vga_blue    = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Directed bench on a 16x8 miniature raster, latency 1 and latency 3.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b1;
    logic [3:0] r_in = 4'hF, g_in = 4'hA, b_in = 4'h5;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) ifa ();
    vga_timing_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) ifb ();

    assign ifa.pix_en = pix_en;
    assign ifa.red    = r_in;
    assign ifa.green  = g_in;
    assign ifa.blue   = b_in;
    assign ifb.pix_en = pix_en;
    assign ifb.red    = r_in;
    assign ifb.green  = g_in;
    assign ifb.blue   = b_in;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(4), .PIXEL_LATENCY(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .vga   (ifa.master)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(4), .PIXEL_LATENCY(3)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .vga   (ifb.master)
    );

    typedef struct {
        int n;
        int x;
        int y;
        int act;
        int hs;
        int vs;
        int r;
        int ls;
        int fs;
    } vec_t;

    vec_t tbl[15];
    int   total = 0;
    int   bad = 0;
    int   n = 0;
    bit   last_en = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        last_en = pix_en;
        if (pix_en) n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        last_en = 1'b0;
    endtask

    // Pin-level expectation for latency 1, active-low syncs, from the enabled tick count.
    function automatic int exp_hs_a(input int k);
        int m;
        m = k - 2;
        if (m < 0) return 1;
        return ((m % 16) >= 10 && (m % 16) <= 12) ? 0 : 1;
    endfunction

    function automatic int exp_r_a(input int k);
        int m;
        m = k - 2;
        if (m < 0) return 0;
        return ((m % 16) < 8 && ((m / 16) % 8) < 4) ? 15 : 0;
    endfunction

    initial begin
        int cnt_hs, cnt_vs, cnt_r, cnt_ls, cnt_fs, fs_n, cnt;

        //           n    x   y act hs vs  r  ls fs
        tbl[0]  = '{  0,  0, 0, 1, 1, 1,  0, 0, 0};
        tbl[1]  = '{  1,  1, 0, 1, 1, 1,  0, 0, 0};
        tbl[2]  = '{  2,  2, 0, 1, 1, 1, 15, 0, 0};
        tbl[3]  = '{  9,  9, 0, 0, 1, 1, 15, 0, 0};
        tbl[4]  = '{ 10, 10, 0, 0, 1, 1,  0, 0, 0};
        tbl[5]  = '{ 12, 12, 0, 0, 0, 1,  0, 0, 0};
        tbl[6]  = '{ 14, 14, 0, 0, 0, 1,  0, 0, 0};
        tbl[7]  = '{ 15, 15, 0, 0, 1, 1,  0, 0, 0};
        tbl[8]  = '{ 16,  0, 1, 1, 1, 1,  0, 1, 0};
        tbl[9]  = '{ 17,  1, 1, 1, 1, 1,  0, 0, 0};
        tbl[10] = '{ 64,  0, 4, 0, 1, 1,  0, 1, 0};
        tbl[11] = '{ 66,  2, 4, 0, 1, 1,  0, 0, 0};
        tbl[12] = '{ 82,  2, 5, 0, 1, 0,  0, 0, 0};
        tbl[13] = '{128,  0, 0, 1, 1, 1,  0, 1, 1};
        tbl[14] = '{130,  2, 0, 1, 1, 1, 15, 0, 0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            while (n < tbl[i].n) step();
            chk($sformatf("n%0d.x", tbl[i].n),   int'(ifa.x),           tbl[i].x);
            chk($sformatf("n%0d.y", tbl[i].n),   int'(ifa.y),           tbl[i].y);
            chk($sformatf("n%0d.act", tbl[i].n), int'(ifa.active),      tbl[i].act);
            chk($sformatf("n%0d.hs", tbl[i].n),  int'(ifa.hsync),       tbl[i].hs);
            chk($sformatf("n%0d.vs", tbl[i].n),  int'(ifa.vsync),       tbl[i].vs);
            chk($sformatf("n%0d.r", tbl[i].n),   int'(ifa.vga_red),     tbl[i].r);
            chk($sformatf("n%0d.ls", tbl[i].n),  int'(ifa.line_start),  tbl[i].ls);
            chk($sformatf("n%0d.fs", tbl[i].n),  int'(ifa.frame_start), tbl[i].fs);
            if (tbl[i].n == 2) begin
                chk("n2.g", int'(ifa.vga_green), 10);
                chk("n2.b", int'(ifa.vga_blue),  5);
            end
        end

        // One whole frame of pins: sync widths, lit pixels and strobe counts.
        cnt_hs = 0; cnt_vs = 0; cnt_r = 0; cnt_ls = 0; cnt_fs = 0; fs_n = -1;
        repeat (128) begin
            step();
            if (ifa.hsync == 1'b0) cnt_hs++;
            if (ifa.vsync == 1'b0) cnt_vs++;
            if (ifa.vga_red != 4'd0) cnt_r++;
            if (ifa.line_start) cnt_ls++;
            if (ifa.frame_start) begin cnt_fs++; fs_n = n; end
        end
        chk("frame.hs_low", cnt_hs, 24);
        chk("frame.vs_low", cnt_vs, 32);
        chk("frame.lit",    cnt_r,  32);
        chk("frame.ls",     cnt_ls, 8);
        chk("frame.fs",     cnt_fs, 1);
        chk("frame.fs_n",   fs_n,   256);

        // pix_en toggling: everything advances on enabled ticks only, strobes stay one clk.
        do_reset();
        cnt_ls = 0;
        for (int k = 0; k < 80; k++) begin
            pix_en = (k % 2 == 0);
            step();
            chk($sformatf("tog%0d.x", k),  int'(ifa.x),          n % 16);
            chk($sformatf("tog%0d.hs", k), int'(ifa.hsync),      exp_hs_a(n));
            chk($sformatf("tog%0d.r", k),  int'(ifa.vga_red),    exp_r_a(n));
            chk($sformatf("tog%0d.ls", k), int'(ifa.line_start),
                (last_en && n > 0 && n % 16 == 0) ? 1 : 0);
            if (ifa.line_start) cnt_ls++;
        end
        chk("tog.ls_count", cnt_ls, 2);
        pix_en = 1'b1;

        // Asynchronous reset mid-cycle while hsync is asserted.
        do_reset();
        while (n < 44) step();
        chk("pre_rst.hs", int'(ifa.hsync),   0);
        chk("pre_rst.x",  int'(ifa.x),       12);
        #2 reset = 1'b1;
        #1;
        chk("rst.x",   int'(ifa.x),           0);
        chk("rst.y",   int'(ifa.y),           0);
        chk("rst.act", int'(ifa.active),      1);
        chk("rst.hs",  int'(ifa.hsync),       1);
        chk("rst.vs",  int'(ifa.vsync),       1);
        chk("rst.r",   int'(ifa.vga_red),     0);
        chk("rst.ls",  int'(ifa.line_start),  0);
        chk("rst.fs",  int'(ifa.frame_start), 0);
        chk("rst_b.hs", int'(ifb.hsync),      0);
        chk("rst_b.vs", int'(ifb.vsync),      0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        cnt_fs = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk($sformatf("post_rst%0d.x", k),  int'(ifa.x),     k);
            chk($sformatf("post_rst%0d.hs", k), int'(ifa.hsync), 1);
            if (ifa.frame_start) cnt_fs++;
        end
        chk("post_rst.fs", cnt_fs, 0);

        // Latency 3, active-high syncs.
        do_reset();
        while (n < 3) step();
        chk("b.n3.r", int'(ifb.vga_red), 0);
        step();
        chk("b.n4.r", int'(ifb.vga_red), 15);
        cnt = 0;
        while (ifb.hsync == 1'b0 && cnt < 40) begin cnt++; step(); end
        chk("b.hs_rise_n", n, 14);
        cnt = 0;
        while (ifb.hsync == 1'b1 && cnt < 40) begin cnt++; step(); end
        chk("b.hs_width", cnt, 3);
        while (n < 83) step();
        chk("b.n83.vs", int'(ifb.vsync), 0);
        step();
        chk("b.n84.vs", int'(ifb.vsync), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
